// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: BTB entry layout,
// 2-bit counter encodings and the default table depth.
package bp_pkg;

    localparam int unsigned BP_ENTRIES = 16;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Tag is sized for the smallest legal table; unused upper bits stay zero.
    typedef struct packed {
        logic        valid;
        logic [61:0] tag;
        logic [63:0] target;
        logic [1:0]  ctr;
    } bp_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating up/down counter.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       inc_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, EX-stage mispredict detection and redirect.
// Optional BP_STATS_EN adds update / mispredict event counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = BP_ENTRIES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pc,
    output logic        branch_taken,
    output logic [63:0] branch_target,
    input  logic        upd_valid,
    input  logic [63:0] upd_pc,
    input  logic        upd_is_branch,
    input  logic        upd_taken,
    input  logic [63:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [63:0] upd_pred_target,
    output logic        prediction_incorrect,
    output logic [63:0] corrected_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    bp_entry_t        table_q [ENTRIES];
    bp_entry_t        lk_entry;
    bp_entry_t        upd_entry;
    bp_entry_t        entry_d;
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [61:0]      lk_tag;
    logic [61:0]      upd_tag;
    logic             lk_hit;
    logic             upd_hit;
    logic             entry_we;
    logic [1:0]       ctr_next;
    logic             unused_lsbs;

    assign unused_lsbs = ^{pc[1:0], upd_pc[1:0]};

    assign lk_idx    = pc[IDX_W+1:2];
    assign lk_tag    = 62'(pc[63:IDX_W+2]);
    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_tag   = 62'(upd_pc[63:IDX_W+2]);
    assign lk_entry  = table_q[lk_idx];
    assign upd_entry = table_q[upd_idx];

    sat_counter2 u_ctr (
        .ctr_i (upd_entry.ctr),
        .inc_i (upd_taken),
        .ctr_o (ctr_next)
    );

    // Lookup reads pre-edge table contents; no bypass from the update port.
    always_comb begin
        lk_hit        = lk_entry.valid && (lk_entry.tag == lk_tag);
        branch_taken  = rst_n && lk_hit && lk_entry.ctr[1];
        branch_target = (rst_n && lk_hit) ? lk_entry.target : pc + 64'd4;
    end

    always_comb begin
        prediction_incorrect = upd_valid &&
            ((upd_is_branch && ((upd_taken != upd_pred_taken) ||
                                (upd_taken && (upd_target != upd_pred_target)))) ||
             (!upd_is_branch && upd_pred_taken));
        corrected_pc = (upd_is_branch && upd_taken) ? upd_target : upd_pc + 64'd4;
    end

    always_comb begin
        upd_hit  = upd_entry.valid && (upd_entry.tag == upd_tag);
        entry_we = 1'b0;
        entry_d  = upd_entry;
        if (upd_valid) begin
            if (upd_is_branch) begin
                if (upd_hit) begin
                    entry_we    = 1'b1;
                    entry_d.ctr = ctr_next;
                    if (upd_taken) entry_d.target = upd_target;
                end else if (upd_taken) begin
                    entry_we       = 1'b1;
                    entry_d.valid  = 1'b1;
                    entry_d.tag    = upd_tag;
                    entry_d.target = upd_target;
                    entry_d.ctr    = WT;
                end
            end else if (upd_hit) begin
                // Non-branch aliasing onto a live entry: drop the stale prediction.
                entry_we      = 1'b1;
                entry_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
                table_q[i].ctr   <= WNT;
            end
        end else if (entry_we) begin
            table_q[upd_idx] <= entry_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_updates_q, stat_updates_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_updates_d     = stat_updates_q + 32'(upd_valid);
        stat_mispredicts_d = stat_mispredicts_q + 32'(prediction_incorrect);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_updates_q     <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            stat_updates_q     <= stat_updates_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_updates     = stat_updates_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios then random traffic against a table model.
module tb_branch_predictor;

    localparam int NENT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] pc;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_is_branch;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic        upd_pred_taken;
    logic [63:0] upd_pred_target;
    logic        prediction_incorrect;
    logic [63:0] corrected_pc;

    int errors = 0;
    int checks = 0;

    // Model: one slot per index, keyed by the address bits above the index.
    bit          m_valid [NENT];
    logic [63:0] m_key   [NENT];
    logic [63:0] m_tgt   [NENT];
    int          m_ctr   [NENT];

    logic        obs_taken, obs_mis;
    logic [63:0] obs_target, obs_cpc;

    logic [63:0] pool [8];

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(NENT)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .pc                   (pc),
        .branch_taken         (branch_taken),
        .branch_target        (branch_target),
        .upd_valid            (upd_valid),
        .upd_pc               (upd_pc),
        .upd_is_branch        (upd_is_branch),
        .upd_taken            (upd_taken),
        .upd_target           (upd_target),
        .upd_pred_taken       (upd_pred_taken),
        .upd_pred_target      (upd_pred_target),
        .prediction_incorrect (prediction_incorrect),
        .corrected_pc         (corrected_pc)
    );

    function automatic int idx_of(logic [63:0] a);
        return int'((a / 4) % NENT);
    endfunction

    function automatic logic [63:0] key_of(logic [63:0] a);
        return a / (4 * NENT);
    endfunction

    function automatic bit m_hit(logic [63:0] a);
        return m_valid[idx_of(a)] && (m_key[idx_of(a)] == key_of(a));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit uv, input bit ib, input bit tk,
                                input logic [63:0] upc, input logic [63:0] utgt);
        int i;
        if (!r) begin
            for (int k = 0; k < NENT; k++) begin
                m_valid[k] = 0;
                m_ctr[k]   = 1;
            end
        end else if (uv) begin
            i = idx_of(upc);
            if (ib) begin
                if (m_hit(upc)) begin
                    m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                  : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                    if (tk) m_tgt[i] = utgt;
                end else if (tk) begin
                    m_valid[i] = 1;
                    m_key[i]   = key_of(upc);
                    m_tgt[i]   = utgt;
                    m_ctr[i]   = 2;
                end
            end else if (m_hit(upc)) begin
                m_valid[i] = 0;
            end
        end
    endtask

    // One clock cycle: drive, check combinational outputs, then clock the model.
    task automatic cyc(input bit r, input logic [63:0] lpc, input bit uv, input bit ib,
                       input bit tk, input logic [63:0] upc, input logic [63:0] utgt,
                       input bit ptk, input logic [63:0] ptgt);
        bit          e_taken, e_mis;
        logic [63:0] e_target, e_cpc;
        rst_n = r; pc = lpc; upd_valid = uv; upd_is_branch = ib; upd_taken = tk;
        upd_pc = upc; upd_target = utgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
        e_taken  = r && m_hit(lpc) && (m_ctr[idx_of(lpc)] >= 2);
        e_target = (r && m_hit(lpc)) ? m_tgt[idx_of(lpc)] : lpc + 64'd4;
        e_mis    = uv && ((ib && ((tk != ptk) || (tk && (utgt != ptgt)))) || (!ib && ptk));
        e_cpc    = (ib && tk) ? utgt : upc + 64'd4;
        #3;
        obs_taken = branch_taken; obs_target = branch_target;
        obs_mis = prediction_incorrect; obs_cpc = corrected_pc;
        chk("taken", {63'd0, obs_taken}, {63'd0, e_taken});
        chk("target", obs_target, e_target);
        chk("mispredict", {63'd0, obs_mis}, {63'd0, e_mis});
        chk("corrected_pc", obs_cpc, e_cpc);
        @(posedge clk);
        model_update(r, uv, ib, tk, upc, utgt);
        #1;
    endtask

    task automatic look(input logic [63:0] lpc);
        cyc(1, lpc, 0, 0, 0, 64'h0, 64'h0, 0, 64'h0);
    endtask

    task automatic br(input logic [63:0] upc, input bit tk, input logic [63:0] utgt);
        cyc(1, 64'h0, 1, 1, tk, upc, utgt, 0, upc + 64'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] upc, lpc, utgt, ptgt;
        bit          ptk;
        pool[0] = 64'h100;  pool[1] = 64'h140;  pool[2] = 64'h180;  pool[3] = 64'h104;
        pool[4] = 64'hFFFF_FFFF_FFFF_FFFC;  pool[5] = 64'h200;  pool[6] = 64'h1100;
        pool[7] = 64'h3C;
        @(posedge clk); #1;
        cyc(0, 64'h100, 0, 0, 0, 64'h0, 64'h0, 0, 64'h0);
        cyc(0, 64'h100, 1, 1, 1, 64'h100, 64'h200, 0, 64'h0);

        // Reset state lookup
        look(64'h100);
        chk("rst_taken", {63'd0, obs_taken}, 64'd0);
        chk("rst_target", obs_target, 64'h104);

        // Allocate; same-cycle lookup still sees the old contents
        cyc(1, 64'h100, 1, 1, 1, 64'h100, 64'h200, 0, 64'h104);
        chk("alloc_mis", {63'd0, obs_mis}, 64'd1);
        chk("alloc_cpc", obs_cpc, 64'h200);
        chk("no_bypass", {63'd0, obs_taken}, 64'd0);
        look(64'h100);
        chk("alloc_taken", {63'd0, obs_taken}, 64'd1);
        chk("alloc_target", obs_target, 64'h200);

        // Counter walk: 2->1->0, back to 2, saturate at 3
        br(64'h100, 0, 64'h0); br(64'h100, 0, 64'h0);
        look(64'h100);
        chk("ctr0_taken", {63'd0, obs_taken}, 64'd0);
        br(64'h100, 1, 64'h200); br(64'h100, 1, 64'h200);
        look(64'h100);
        chk("ctr2_taken", {63'd0, obs_taken}, 64'd1);
        br(64'h100, 1, 64'h200); br(64'h100, 1, 64'h200); br(64'h100, 1, 64'h200);
        br(64'h100, 0, 64'h0);
        look(64'h100);
        chk("sat3_then_dec", {63'd0, obs_taken}, 64'd1);
        br(64'h100, 0, 64'h0);
        look(64'h100);
        chk("sat3_dec2", {63'd0, obs_taken}, 64'd0);

        // Alias at same index replaces the occupant
        br(64'h140, 1, 64'h300);
        look(64'h100);
        chk("alias_old_miss", obs_target, 64'h104);
        look(64'h140);
        chk("alias_new_taken", {63'd0, obs_taken}, 64'd1);
        chk("alias_new_target", obs_target, 64'h300);

        // Non-branch hitting an entry invalidates it
        cyc(1, 64'h0, 1, 0, 0, 64'h140, 64'h0, 1, 64'h300);
        chk("nonbr_mis", {63'd0, obs_mis}, 64'd1);
        chk("nonbr_cpc", obs_cpc, 64'h144);
        look(64'h140);
        chk("nonbr_inval", obs_target, 64'h144);

        // Wrap-around and mid-sequence reset
        look(64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_target", obs_target, 64'h0);
        cyc(1, 64'h0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0, 64'h0);
        chk("wrap_cpc", obs_cpc, 64'h0);
        br(64'h180, 1, 64'h500);
        look(64'h180);
        chk("pre_rst_hit", obs_target, 64'h500);
        cyc(0, 64'h180, 1, 1, 1, 64'h180, 64'h600, 0, 64'h0);
        chk("in_rst_taken", {63'd0, obs_taken}, 64'd0);
        look(64'h180);
        chk("post_rst_miss", obs_target, 64'h184);

        for (int n = 0; n < 600; n++) begin
            upc  = pool[$urandom_range(0, 7)];
            lpc  = pool[$urandom_range(0, 7)];
            utgt = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)]
                                               : {32'h0, $urandom} & ~64'h3;
            if ($urandom_range(0, 1) == 1) begin
                ptk  = m_hit(upc) && (m_ctr[idx_of(upc)] >= 2);
                ptgt = m_hit(upc) ? m_tgt[idx_of(upc)] : upc + 64'd4;
            end else begin
                ptk  = 1'($urandom);
                ptgt = pool[$urandom_range(0, 7)];
            end
            cyc(($urandom_range(0, 39) != 0), lpc, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 4) != 0), 1'($urandom), upc, utgt, ptk, ptgt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
